// File: rtl/beta_io_pkg.sv
// Shared definitions for the beta2 memory-side I/O bridge: I/O page tag,
// register offsets and bit positions within STATUS/CTRL/ACK.
package beta_io_pkg;

  localparam logic [2:0] IO_PAGE = 3'b111;

  typedef enum logic [2:0] {
    REG_PT_DATA = 3'd0,
    REG_STATUS  = 3'd1,
    REG_RELOAD  = 3'd2,
    REG_TCOUNT  = 3'd3,
    REG_CTRL    = 3'd4,
    REG_ACK     = 3'd5
  } io_reg_e;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_LOWATER   = 1;
  localparam int unsigned ST_PEND      = 2;
  localparam int unsigned ST_OVF       = 3;

  localparam int unsigned CTRL_TIMER_EN  = 0;
  localparam int unsigned CTRL_TIMER_IRQ = 1;
  localparam int unsigned CTRL_LOW_IRQ   = 2;

  localparam int unsigned ACK_PEND = 0;
  localparam int unsigned ACK_OVF  = 1;

  // Supervisor bit (31) is not part of the decode.
  function automatic logic io_page_hit(input logic [31:0] ma);
    return ma[30:28] == IO_PAGE;
  endfunction

endpackage

// File: rtl/beta_io_bridge_if.sv
// beta2 synchronous memory port: address/write data/write enable from the CPU,
// read data back one cycle later.
interface beta_io_bridge_if;
  logic [31:0] ma;
  logic [31:0] cpu_wd;
  logic        mwe;
  logic [31:0] cpu_rd;

  modport master (output ma, output cpu_wd, output mwe, input cpu_rd);
  modport slave  (input ma, input cpu_wd, input mwe, output cpu_rd);
endinterface

// File: rtl/beta_io_bridge_point_fifo.sv
// Point FIFO between software writes and the galvo/DAC stage. A push while
// full is still accepted when a pop happens in the same cycle.
module point_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Accept/drop decision and pointer/count update
  always_comb begin
    full     = count_q == CW'(DEPTH);
    empty    = count_q == '0;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    dropped  = push & ~do_push;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    count    = count_q;
    head     = mem_q[rd_ptr_q];
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset so it maps to distributed RAM
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/beta_io_bridge.sv
// beta2 memory-side bridge: RAM pass-through, I/O page register file,
// point FIFO, interval timer and irq generation.
module beta_io_bridge
  import beta_io_pkg::*;
#(
  parameter int unsigned RAM_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOWATER    = 4,
  parameter logic [30:0] IRQ_VEC    = 31'h8
) (
  input  logic              clk,
  input  logic              reset_n,
  beta_io_bridge_if.slave   cpu,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wd,
  input  logic [31:0]       ram_rd,
  output logic              irq,
  output logic [30:0]       xadr,
  output logic              pt_valid,
  output logic [31:0]       pt_data,
  input  logic              pt_ready
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          io_sel, wr_io, push, pop, lowater, expire;
  logic          reload_wr, ctrl_wr, ack_wr;
  logic [2:0]    offset;
  logic          fifo_full, fifo_empty, fifo_dropped;
  logic [CW-1:0] fifo_count;

  logic        io_sel_q, io_sel_d;
  logic [31:0] io_rd_q, io_rd_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] tcount_q, tcount_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic        unused_ma;

  assign unused_ma = ^cpu.ma;

  point_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (cpu.cpu_wd),
    .pop       (pop),
    .head      (pt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (fifo_dropped)
  );

  // Decode, register writes, timer, irq cause and read-data selection
  always_comb begin
    io_sel    = io_page_hit(cpu.ma);
    offset    = cpu.ma[4:2];
    wr_io     = io_sel & cpu.mwe;
    push      = wr_io & (offset == REG_PT_DATA);
    reload_wr = wr_io & (offset == REG_RELOAD);
    ctrl_wr   = wr_io & (offset == REG_CTRL);
    ack_wr    = wr_io & (offset == REG_ACK);
    pop       = ~fifo_empty & pt_ready;
    lowater   = 32'(fifo_count) < LOWATER;

    ram_addr = cpu.ma[RAM_AW+1:2];
    ram_we   = cpu.mwe & ~io_sel;
    ram_wd   = cpu.cpu_wd;

    reload_d = reload_wr ? cpu.cpu_wd : reload_q;
    ctrl_d   = ctrl_wr ? cpu.cpu_wd[2:0] : ctrl_q;

    expire   = ctrl_q[CTRL_TIMER_EN] & (tcount_q == '0);
    tcount_d = tcount_q;
    if (reload_wr)                   tcount_d = cpu.cpu_wd;
    else if (ctrl_q[CTRL_TIMER_EN])  tcount_d = expire ? reload_q : tcount_q - 32'd1;

    // Setting a flag takes priority over acknowledging it in the same cycle.
    pend_d = expire | (pend_q & ~(ack_wr & cpu.cpu_wd[ACK_PEND]));
    ovf_d  = fifo_dropped | (ovf_q & ~(ack_wr & cpu.cpu_wd[ACK_OVF]));
    irq_d  = (pend_q & ctrl_q[CTRL_TIMER_IRQ]) | (lowater & ctrl_q[CTRL_LOW_IRQ]);

    io_sel_d = io_sel;
    io_rd_d  = '0;
    case (offset)
      REG_STATUS: begin
        io_rd_d[ST_FULL]    = fifo_full;
        io_rd_d[ST_LOWATER] = lowater;
        io_rd_d[ST_PEND]    = pend_q;
        io_rd_d[ST_OVF]     = ovf_q;
        io_rd_d[15:8]       = 8'(fifo_count);
      end
      REG_RELOAD: io_rd_d = reload_q;
      REG_TCOUNT: io_rd_d = tcount_q;
      REG_CTRL:   io_rd_d = {29'b0, ctrl_q};
      default:    io_rd_d = '0;
    endcase
  end

  // Register file, timer, flags, irq and read pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // io_sel_q resets high so cpu_rd shows the cleared io_rd_q rather
      // than whatever the BRAM is presenting.
      io_sel_q <= 1'b1;
      io_rd_q  <= '0;
      reload_q <= '0;
      tcount_q <= '0;
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      io_sel_q <= io_sel_d;
      io_rd_q  <= io_rd_d;
      reload_q <= reload_d;
      tcount_q <= tcount_d;
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign cpu.cpu_rd = io_sel_q ? io_rd_q : ram_rd;
  assign irq        = irq_q;
  assign xadr       = IRQ_VEC;
  assign pt_valid   = ~fifo_empty;
endmodule

// File: tb/tb_beta_io_bridge.sv
// Directed and randomized checks of beta_io_bridge against a queue-based
// behavioural model of the register map, FIFO and timer.
module tb_beta_io_bridge;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LOW   = 4;
  localparam logic [31:0] IO    = 32'h7000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  beta_io_bridge_if bus ();
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd = '0;
  logic        irq;
  logic [30:0] xadr;
  logic        pt_valid;
  logic [31:0] pt_data;
  logic        pt_ready = 1'b0;

  beta_io_bridge #(.RAM_AW(12), .FIFO_DEPTH(DEPTH), .LOWATER(LOW), .IRQ_VEC(31'h8)) dut (
    .clk(clk), .reset_n(reset_n), .cpu(bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd),
    .irq(irq), .xadr(xadr), .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready)
  );

  // Bench-side block RAM, read-before-write
  logic [31:0] tb_mem [4096];
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_wd;
    ram_rd <= tb_mem[ram_addr];
  end

  // Reference model state
  logic [31:0] m_q [$];
  bit          m_ovf, m_pend, m_irq;
  logic [31:0] m_reload, m_tcount, m_rd;
  logic [2:0]  m_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_pend = 0; m_irq = 0;
    m_reload = '0; m_tcount = '0; m_ctrl = '0; m_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    int sz;
    sz = m_q.size();
    case (off)
      3'd1:    return {16'h0, 8'(sz), 4'h0, m_ovf, m_pend, sz < LOW, sz == DEPTH};
      3'd2:    return m_reload;
      3'd3:    return m_tcount;
      3'd4:    return {29'h0, m_ctrl};
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ma, input logic [31:0] wd, input logic we);
    bus.ma = ma; bus.cpu_wd = wd; bus.mwe = we;
  endtask

  // One bus cycle: check combinational RAM strobes, advance model, check registered outputs
  task automatic cycle();
    bit io, wr, push, pop, expire, irq_n;
    logic [2:0] off;
    logic [31:0] wd, rdval, tc_n;
    int sz;
    #1;
    io  = bus.ma[30:28] == 3'b111;
    off = bus.ma[4:2];
    wd  = bus.cpu_wd;
    wr  = io && bus.mwe;
    chk("ram_we", ram_we, bus.mwe && !io);
    if (!io) chk("ram_addr", ram_addr, bus.ma[13:2]);
    sz     = m_q.size();
    rdval  = io ? model_read(off) : tb_mem[bus.ma[13:2]];
    pop    = sz > 0 && pt_ready;
    push   = wr && off == 0;
    irq_n  = (m_pend && m_ctrl[1]) || (sz < LOW && m_ctrl[2]);
    expire = m_ctrl[0] && m_tcount == 0;
    if (wr && off == 2)  tc_n = wd;
    else if (m_ctrl[0])  tc_n = (m_tcount == 0) ? m_reload : m_tcount - 1;
    else                 tc_n = m_tcount;
    @(posedge clk); #1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(wd);
      else m_ovf = 1;
      end else if (wr && off == 5 && wd[1]) m_ovf = 0;
    if (push && sz == DEPTH && !pop) m_ovf = 1;
    if (expire) m_pend = 1;
    else if (wr && off == 5 && wd[0]) m_pend = 0;
    if (wr && off == 2) m_reload = wd;
    if (wr && off == 4) m_ctrl = wd[2:0];
    m_tcount = tc_n;
    m_irq = irq_n;
    m_rd  = rdval;
    chk("cpu_rd", bus.cpu_rd, m_rd);
    chk("irq", irq, m_irq);
    chk("pt_valid", pt_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("pt_data", pt_data, m_q[0]);
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cpu_rd", bus.cpu_rd, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic io_wr(input logic [2:0] off, input logic [31:0] wd);
    drive(IO | {27'h0, off, 2'b0}, wd, 1'b1);
    cycle();
  endtask

  task automatic io_rd(input logic [2:0] off);
    drive(IO | {27'h0, off, 2'b0}, '0, 1'b0);
    cycle();
  endtask

  initial begin
    int n;
    logic [31:0] first, last, ma;
    for (int i = 0; i < 4096; i++) tb_mem[i] = '0;
    drive('0, '0, 1'b0);
    model_reset();
    #1;
    chk("init_cpu_rd", bus.cpu_rd, 0);
    chk("init_irq", irq, 0);
    chk("init_pt_valid", pt_valid, 0);
    chk("xadr", {1'b0, xadr}, 32'h8);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // RAM store then load
    drive(32'h40, 32'hDEADBEEF, 1'b1);
    cycle();
    drive(32'h40, 32'h0, 1'b0);
    cycle();
    chk("ram_load", bus.cpu_rd, 32'hDEADBEEF);
    chk("ram_we_once", ram_we, 0);

    // FIFO fill past full with downstream stalled
    do_reset();
    pt_ready = 1'b0;
    for (int i = 1; i <= 17; i++) io_wr(3'd0, 32'h1000 + i);
    io_rd(3'd1);
    chk("status_full_ovf", bus.cpu_rd, 32'h0000_1009);
    cycle();
    chk("stall_hold", pt_data, 32'h1001);
    pt_ready = 1'b1;
    drive('0, '0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", pt_data, 32'h1000 + i);
      cycle();
    end
    chk("drained", pt_valid, 0);

    // Full FIFO with simultaneous push and pop
    io_wr(3'd5, 32'h2);
    pt_ready = 1'b0;
    for (int i = 1; i <= 16; i++) io_wr(3'd0, 32'h2000 + i);
    pt_ready = 1'b1;
    io_wr(3'd0, 32'h2FFF);
    pt_ready = 1'b0;
    io_rd(3'd1);
    chk("status_full_pushpop", bus.cpu_rd, 32'h0000_1001);
    pt_ready = 1'b1;
    drive('0, '0, 1'b0);
    first = pt_data;
    last  = '0;
    for (int i = 0; i < 16; i++) begin
      last = pt_data;
      cycle();
    end
    chk("pushpop_first", first, 32'h2002);
    chk("pushpop_last", last, 32'h2FFF);

    // Timer interrupt latency and acknowledge
    do_reset();
    io_wr(3'd2, 32'd9);
    io_wr(3'd4, 32'd3);
    drive('0, '0, 1'b0);
    n = 0;
    while (!irq && n < 30) begin
      cycle();
      n++;
    end
    chk("timer_latency", n, 11);
    io_wr(3'd5, 32'h1);
    drive('0, '0, 1'b0);
    cycle();
    chk("timer_ack_irq", irq, 0);
    io_wr(3'd4, 32'd0);

    // Low-water interrupt
    do_reset();
    pt_ready = 1'b0;
    io_wr(3'd4, 32'd4);
    drive('0, '0, 1'b0);
    cycle();
    chk("lowater_irq_on", irq, 1);
    for (int i = 0; i < 4; i++) io_wr(3'd0, 32'h3000 + i);
    chk("lowater_irq_lag", irq, 1);
    drive('0, '0, 1'b0);
    cycle();
    chk("lowater_irq_off", irq, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      pt_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 7) begin
        ma = {$urandom_range(0, 1) == 1, 3'b111, 23'($urandom), 3'($urandom_range(0, 7)), 2'b0};
        case (ma[4:2])
          3'd2:    drive(ma, 32'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
          3'd0:    drive(ma, $urandom, $urandom_range(0, 1) == 1);
          default: drive(ma, $urandom, $urandom_range(0, 2) == 0);
        endcase
      end else begin
        ma = $urandom;
        ma[30:28] = 3'($urandom_range(0, 6));
        drive(ma, $urandom, $urandom_range(0, 1) == 1);
      end
      cycle();
    end

    // Asynchronous reset with points queued
    do_reset();
    pt_ready = 1'b0;
    io_wr(3'd4, 32'd4);
    for (int i = 0; i < 3; i++) io_wr(3'd0, 32'h4000 + i);
    drive('0, '0, 1'b0);
    cycle();
    chk("pre_reset_irq", irq, 1);
    chk("pre_reset_valid", pt_valid, 1);
    do_reset();
    io_rd(3'd1);
    chk("post_reset_status", bus.cpu_rd, 32'h0000_0002);
    io_rd(3'd4);
    chk("post_reset_ctrl", bus.cpu_rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
